cim_shift_accumulator: RTL and testbench
========================================

Name: cim_shift_accumulator

Overview:
- Downstream consumer of the 10-bit column partial product P produced by an 8-cell XNOR-SRAM row group.
- Activation bit-planes are applied MSB-first, one plane per beat.
- Each beat, the block merges P's two 5-bit halves into one signed column word according to the precision mode, then shift-accumulates that word into a signed MAC result.
- The result is delivered on a valid/ready output to the PE-group adder pipeline.

Parameters:
- ACC_W, 20, accumulator/result width in bits (two's complement, wraps modulo 2^ACC_W).
- MAX_BITS, 8, maximum number of activation bit-planes per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin an operation; honoured only when idle=1.
- mode  input  3  precision: 000 = INT8 weight, 001 = dual-INT4 weight, others = binary. Latched on start.
- n_bits  input  4  number of activation bit-planes, latched on start. 0 means 8; values >8 clamp to 8; forced to 1 in binary mode.
- in_valid  input  1  P_in carries a valid bit-plane partial product.
- in_ready  output  1  block accepts a beat; high only in ACCUM.
- P_in  input  10  partial product {hi = P_in[9:5], lo = P_in[4:0]}.
- out_valid  output  1  acc_out valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  signed accumulated result.
- idle  output  1  high in IDLE; start is accepted.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) sets: state=IDLE, acc=0, beat count=0, latched mode=000, latched n_bits=1, out_valid=0, in_ready=0, acc_out=0, idle=1. Reset takes priority over every other event, including in the middle of ACCUM or DONE; any partial result is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - idle=1.
  - On start=1: latch mode and effective n_bits, clear acc and beat count, go to ACCUM.
  - in_valid is ignored in IDLE.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid=1; no beat is accepted when in_valid=0.
  - Word formation from P_in:
    - mode 000: word = $signed(hi)*16 + $unsigned(lo).
    - mode 001: word = $signed(hi) + $signed(lo).
    - other modes: word = $unsigned(hi) + $unsigned(lo).
    - word is sign-extended to ACC_W.
  - Accumulation rule for each accepted beat:
    - First beat, signed mode (000/001) and n_bits>1: acc = -word (MSB plane has negative weight).
    - First beat otherwise: acc = word.
    - Later beats: acc = (acc<<1) + word.
  - After the beat that reaches count = n_bits, go to DONE.
  - start is ignored in ACCUM.
- DONE:
  - out_valid=1 and acc_out=acc.
  - acc_out is held stable while out_ready=0.
  - in_ready=0; start is ignored.
  - On out_ready=1: go to IDLE, and out_valid drops on the next cycle.
- Latency: out_valid rises in the cycle after the last beat is accepted. Minimum operation length is start + n_bits beats + 1 cycle.
- acc_out is registered. It holds the last result after leaving DONE and is only cleared by reset.
- Overflow: with default widths no overflow occurs (maximum |result| < 2^18); otherwise the result wraps silently.
- There are no simultaneous-event conflicts, because start, in_valid and out_ready are each examined only in their own state.

Test Plan:
- INT8, n_bits=2:
  - Stimulus: start mode=000; beat P_in={5'd1,5'd2}, then beat P_in={5'd0,5'd3}.
  - Required: acc after beat 1 = -18; acc_out = -33, out_valid one cycle after beat 2.
- Dual-INT4, n_bits=4:
  - Stimulus: mode=001; four beats of P_in=10'h3E2 (hi=-1, lo=2, word=1).
  - Required: acc sequence -1,-1,-1,-1; acc_out = -1.
- Binary mode:
  - Stimulus: mode=010, n_bits=5; one beat P_in={5'd5,5'd3}.
  - Required: n_bits is forced to 1; acc_out = 8 after one beat; a second in_valid sees in_ready=0.
- Backpressure and gaps:
  - Stimulus: in_valid low for 2 cycles in the middle of ACCUM; then hold out_ready=0 for 3 cycles in DONE while pulsing start.
  - Required: the gap cycles leave acc unchanged; acc_out stays stable and out_valid stays 1; start is ignored; out_ready=1 returns the block to IDLE.
- Reset mid-operation:
  - Stimulus: rst=1 after 1 of 4 beats.
  - Required: next cycle idle=1, out_valid=0, in_ready=0, acc_out=0; a fresh operation then yields the correct result.
- n_bits boundaries:
  - Stimulus: n_bits=0 and n_bits=12, in mode 000.
  - Required: each operation takes exactly 8 beats; with all beats P_in={5'd0,5'd1}, acc_out = -128+127 = -1.

Source files
------------

// File: rtl/cim_shift_accumulator.sv
// Shift-accumulator for bit-serial CIM: merges each 10-bit column partial product into a signed
// word and accumulates activation bit-planes MSB-first, delivering the result on valid/ready.
module cim_shift_accumulator #(
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned MAX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [3:0]       n_bits,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       P_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             idle
);

    localparam int unsigned CntW  = $clog2(MAX_BITS + 1);
    localparam int unsigned WordW = 11;

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e            state_q;
    logic [2:0]        mode_q;
    logic [CntW-1:0]   nbits_q, count_q, count_inc, nbits_eff;
    logic [ACC_W-1:0]  acc_q, acc_d, word_ext;
    logic [WordW-1:0]  word;
    logic [4:0]        hi, lo;
    logic              signed_mode;

    assign hi          = P_in[9:5];
    assign lo          = P_in[4:0];
    assign signed_mode = (mode_q[2:1] == 2'b00);
    assign count_inc   = count_q + CntW'(1);

    always_comb begin
        nbits_eff = CntW'(n_bits);
        if (mode[2:1] != 2'b00) begin
            nbits_eff = CntW'(1);
        end else if (n_bits == 4'd0 || 32'(n_bits) > MAX_BITS) begin
            nbits_eff = CntW'(MAX_BITS);
        end
    end

    always_comb begin
        case (mode_q)
            3'b000:  word = {{2{hi[4]}}, hi, 4'b0000} + {6'b0, lo};
            3'b001:  word = {{6{hi[4]}}, hi} + {{6{lo[4]}}, lo};
            default: word = {6'b0, hi} + {6'b0, lo};
        endcase
        word_ext = {{(ACC_W - WordW){word[WordW-1]}}, word};
    end

    // The MSB plane carries negative weight in signed modes, unless it is the only plane.
    always_comb begin
        if (count_q == '0) begin
            acc_d = (signed_mode && nbits_q > CntW'(1)) ? -word_ext : word_ext;
        end else begin
            acc_d = (acc_q << 1) + word_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            count_q   <= '0;
            mode_q    <= 3'b000;
            nbits_q   <= CntW'(1);
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            acc_out   <= '0;
            idle      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q   <= mode;
                        nbits_q  <= nbits_eff;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= StAccum;
                        idle     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        count_q <= count_inc;
                        if (count_inc == nbits_q) begin
                            state_q   <= StDone;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            acc_out   <= acc_d;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        idle      <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_shift_accumulator.sv
// Randomized self-checking bench for cim_shift_accumulator against an arithmetic reference model.
module tb_cim_shift_accumulator;

    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, out_ready;
    logic [2:0]       mode;
    logic [3:0]       n_bits;
    logic [9:0]       P_in;
    logic             in_ready, out_valid, idle;
    logic [ACC_W-1:0] acc_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] p_tab [8];

    always #5 clk = ~clk;

    cim_shift_accumulator #(.ACC_W(ACC_W), .MAX_BITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .n_bits(n_bits),
        .in_valid(in_valid), .in_ready(in_ready), .P_in(P_in), .out_valid(out_valid),
        .out_ready(out_ready), .acc_out(acc_out), .idle(idle)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int eff_bits(input int m, input int nb);
        if (m > 1) return 1;
        if (nb == 0 || nb > 8) return 8;
        return nb;
    endfunction

    function automatic longint word_of(input int m, input logic [9:0] p);
        longint hu, lu, hs, ls;
        hu = longint'(p[9:5]);
        lu = longint'(p[4:0]);
        hs = (hu >= 16) ? hu - 32 : hu;
        ls = (lu >= 16) ? lu - 32 : lu;
        if (m == 0) return hs * 16 + lu;
        if (m == 1) return hs + ls;
        return hu + lu;
    endfunction

    // Plane i carries weight 2^(n-1-i); the MSB plane is negative in signed modes when n>1.
    function automatic longint model(input int m, input int n);
        longint r = 0;
        for (int i = 0; i < n; i++) begin
            longint term = word_of(m, p_tab[i]) * (longint'(1) <<< (n - 1 - i));
            if (i == 0 && m < 2 && n > 1) r -= term;
            else r += term;
        end
        return r;
    endfunction

    task automatic run_op(input int m, input int nb, input int gap_at, input int gap_len,
                          input int bp);
        int neff;
        longint expv;
        longint held;
        neff = eff_bits(m, nb);
        expv = model(m, neff);
        check("idle_before", longint'(idle), 1);
        start = 1'b1; mode = 3'(m); n_bits = 4'(nb);
        @(negedge clk);
        start = 1'b0;
        check("in_ready_accum", longint'(in_ready), 1);
        check("idle_accum", longint'(idle), 0);
        for (int i = 0; i < neff; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0; P_in = 10'($urandom);
                    @(negedge clk);
                    check("gap_no_done", longint'(out_valid), 0);
                    check("gap_in_ready", longint'(in_ready), 1);
                end
            end
            P_in = p_tab[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (i < neff - 1) check("beat_no_done", longint'(out_valid), 0);
        end
        check("out_valid_rise", longint'(out_valid), 1);
        check("in_ready_done", longint'(in_ready), 0);
        check("acc_out", longint'($signed(acc_out)), expv);
        held = longint'(acc_out);
        for (int k = 0; k < bp; k++) begin
            start = 1'b1; in_valid = 1'b1; P_in = 10'($urandom);
            @(negedge clk);
            check("bp_valid", longint'(out_valid), 1);
            check("bp_stable", longint'(acc_out), held);
            check("bp_not_idle", longint'(idle), 0);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ret_idle", longint'(idle), 1);
        check("valid_drop", longint'(out_valid), 0);
        check("acc_hold", longint'($signed(acc_out)), expv);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) p_tab[i] = 10'($urandom);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 3'b000; n_bits = 4'd0; P_in = 10'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_idle", longint'(idle), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_acc_out", longint'(acc_out), 0);

        // INT8, two planes
        p_tab[0] = {5'd1, 5'd2}; p_tab[1] = {5'd0, 5'd3};
        run_op(0, 2, -1, 0, 0);
        check("int8_const", longint'($signed(acc_out)), -33);

        // Dual-INT4, word = 1 every plane
        for (int i = 0; i < 8; i++) p_tab[i] = 10'h3E2;
        run_op(1, 4, -1, 0, 0);
        check("dual4_const", longint'($signed(acc_out)), -1);

        // Binary forces a single plane
        p_tab[0] = {5'd5, 5'd3};
        run_op(2, 5, -1, 0, 0);
        check("binary_const", longint'($signed(acc_out)), 8);

        // Input gaps and output backpressure with start pulses
        fill_random();
        run_op(0, 6, 3, 2, 3);

        // Reset in the middle of an operation
        start = 1'b1; mode = 3'b000; n_bits = 4'd4;
        @(negedge clk);
        start = 1'b0; P_in = 10'($urandom); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idle", longint'(idle), 1);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_in_ready", longint'(in_ready), 0);
        check("mid_rst_acc_out", longint'(acc_out), 0);
        fill_random();
        run_op(1, 3, -1, 0, 1);

        // n_bits boundaries: 0 and 12 both mean 8 planes
        for (int i = 0; i < 8; i++) p_tab[i] = {5'd0, 5'd1};
        run_op(0, 0, -1, 0, 0);
        check("nb0_const", longint'($signed(acc_out)), -1);
        run_op(0, 12, -1, 0, 0);
        check("nb12_const", longint'($signed(acc_out)), -1);

        for (int t = 0; t < 60; t++) begin
            fill_random();
            run_op(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(7, 0)), int'($urandom_range(2, 0)),
                   int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
